// File: rtl/adc_scan_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : adc_scan_sequencer
// Purpose  : Round-robin ADC channel scanner that stores 8-bit samples into a
//            buffer RAM. Define ADC_SEQ_AVG_EN for 4-conversion averaging.
// Revision : 1.0
// ============================================================================
module adc_scan_sequencer #(
  parameter int DEPTH_LOG2 = 5,
  parameter int TIMEOUT    = 1023
) (
  input  logic                  iCLK,
  input  logic                  iRST_n,
  input  logic                  iSTART,
  input  logic                  iABORT,
  input  logic                  iCONT,
  input  logic [7:0]            iCH_MASK,
  input  logic [15:0]           iDIV,
  output logic                  oADC_GO,
  output logic [2:0]            oADC_CH,
  input  logic                  iADC_DONE,
  input  logic [11:0]           iADC_DATA,
  output logic                  oWR_EN,
  output logic [DEPTH_LOG2-1:0] oWR_ADDR,
  output logic [7:0]            oWR_DATA,
  output logic                  oBUSY,
  output logic                  oDONE,
  output logic                  oERR
);

  localparam int TW = $clog2(TIMEOUT + 1);

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    WAIT_TICK = 3'd1,
    CONVERT   = 3'd2,
    WRITE     = 3'd3,
    FINISH    = 3'd4
  } state_t;

  state_t                state_q, state_d;
  logic [DEPTH_LOG2-1:0] addr_q, addr_d;
  logic [15:0]           tick_q, tick_d;
  logic [2:0]            ch_q, ch_d;
  logic [7:0]            mask_q, mask_d;
  logic                  cont_q, cont_d;
  logic [TW-1:0]         to_q, to_d;
  logic                  go_q, go_d;
  logic                  wr_en_q, wr_en_d;
  logic [7:0]            wr_data_q, wr_data_d;
  logic                  busy_q, busy_d;
  logic                  done_q, done_d;
  logic                  err_q, err_d;
`ifdef ADC_SEQ_AVG_EN
  logic [1:0]            cv_q, cv_d;
  logic [13:0]           acc_q, acc_d, acc_sum;
`else
  logic                  unused_data_lsbs;
  assign unused_data_lsbs = ^iADC_DATA[3:0];
`endif

  logic [15:0] div_last;
  logic [2:0]  first_ch, next_ch, cand;

  // A divider of 0 behaves like 1: one WAIT_TICK cycle per sample.
  assign div_last = (iDIV == 16'd0) ? 16'd0 : iDIV - 16'd1;

  always_comb begin
    first_ch = 3'd0;
    for (int i = 7; i >= 0; i--) begin
      if (iCH_MASK[i]) first_ch = 3'(i);
    end
  end

  // Descending scan so the smallest forward offset from ch_q wins.
  always_comb begin
    next_ch = ch_q;
    cand    = ch_q;
    for (int i = 7; i >= 1; i--) begin
      cand = ch_q + 3'(i);
      if (mask_q[cand]) next_ch = cand;
    end
  end

  always_comb begin
    state_d   = state_q;
    addr_d    = addr_q;
    tick_d    = tick_q;
    ch_d      = ch_q;
    mask_d    = mask_q;
    cont_d    = cont_q;
    to_d      = to_q;
    go_d      = go_q;
    wr_en_d   = 1'b0;
    wr_data_d = wr_data_q;
    done_d    = 1'b0;
    err_d     = err_q;
`ifdef ADC_SEQ_AVG_EN
    cv_d      = cv_q;
    acc_d     = acc_q;
    acc_sum   = acc_q + 14'(iADC_DATA);
`endif
    unique case (state_q)
      IDLE: begin
        if (iSTART && (iCH_MASK != 8'd0)) begin
          state_d = WAIT_TICK;
          addr_d  = '0;
          tick_d  = 16'd0;
          ch_d    = first_ch;
          mask_d  = iCH_MASK;
          cont_d  = iCONT;
          err_d   = 1'b0;
        end
      end
      WAIT_TICK: begin
        if (iABORT) begin
          state_d = IDLE;
        end else if (tick_q >= div_last) begin
          tick_d  = 16'd0;
          to_d    = '0;
          go_d    = 1'b1;
          state_d = CONVERT;
`ifdef ADC_SEQ_AVG_EN
          cv_d    = 2'd0;
          acc_d   = 14'd0;
`endif
        end else begin
          tick_d = tick_q + 16'd1;
        end
      end
      CONVERT: begin
        if (iABORT) begin
          state_d = IDLE;
          go_d    = 1'b0;
`ifdef ADC_SEQ_AVG_EN
        end else if (!go_q) begin
          // One idle cycle between averaged conversions re-arms the handshake.
          go_d = 1'b1;
          to_d = '0;
        end else if (iADC_DONE) begin
          go_d  = 1'b0;
          acc_d = acc_sum;
          if (cv_q == 2'd3) begin
            wr_data_d = acc_sum[13:6];
            wr_en_d   = 1'b1;
            state_d   = WRITE;
          end else begin
            cv_d = cv_q + 2'd1;
          end
`else
        end else if (iADC_DONE) begin
          go_d      = 1'b0;
          wr_data_d = iADC_DATA[11:4];
          wr_en_d   = 1'b1;
          state_d   = WRITE;
`endif
        end else if (to_q == TW'(TIMEOUT - 1)) begin
          go_d    = 1'b0;
          err_d   = 1'b1;
          state_d = IDLE;
        end else begin
          to_d = to_q + 1'b1;
        end
      end
      WRITE: begin
        ch_d   = next_ch;
        addr_d = addr_q + 1'b1;
        tick_d = 16'd0;
        if (iABORT) begin
          state_d = IDLE;
        end else if (!cont_q && (addr_q == '1)) begin
          state_d = FINISH;
          done_d  = 1'b1;
        end else begin
          state_d = WAIT_TICK;
        end
      end
      FINISH:  state_d = IDLE;
      default: state_d = IDLE;
    endcase
    busy_d = (state_d != IDLE);
  end

  always_ff @(posedge iCLK or negedge iRST_n) begin
    if (!iRST_n) begin
      state_q   <= IDLE;
      addr_q    <= '0;
      tick_q    <= 16'd0;
      ch_q      <= 3'd0;
      mask_q    <= 8'd0;
      cont_q    <= 1'b0;
      to_q      <= '0;
      go_q      <= 1'b0;
      wr_en_q   <= 1'b0;
      wr_data_q <= 8'd0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      err_q     <= 1'b0;
`ifdef ADC_SEQ_AVG_EN
      cv_q      <= 2'd0;
      acc_q     <= 14'd0;
`endif
    end else begin
      state_q   <= state_d;
      addr_q    <= addr_d;
      tick_q    <= tick_d;
      ch_q      <= ch_d;
      mask_q    <= mask_d;
      cont_q    <= cont_d;
      to_q      <= to_d;
      go_q      <= go_d;
      wr_en_q   <= wr_en_d;
      wr_data_q <= wr_data_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
      err_q     <= err_d;
`ifdef ADC_SEQ_AVG_EN
      cv_q      <= cv_d;
      acc_q     <= acc_d;
`endif
    end
  end

  assign oADC_GO  = go_q;
  assign oADC_CH  = ch_q;
  assign oWR_EN   = wr_en_q;
  assign oWR_ADDR = addr_q;
  assign oWR_DATA = wr_data_q;
  assign oBUSY    = busy_q;
  assign oDONE    = done_q;
  assign oERR     = err_q;

endmodule
`default_nettype wire

// File: doc/adc_scan_sequencer.md
ADC_SCAN_SEQUENCER -- requirements
Module: adc_scan_sequencer

Interface
REQ-001 Parameter DEPTH_LOG2, default 5: log2 of sample buffer depth (32 entries).
REQ-002 Parameter TIMEOUT, default 1023: max iCLK cycles from oADC_GO rise to iADC_DONE.
REQ-003 iCLK  in  1  single clock, all logic on rising edge.
REQ-004 iRST_n  in  1  asynchronous, active-low reset.
REQ-005 iSTART  in  1  one-cycle pulse, starts a capture run.
REQ-006 iABORT  in  1  level, stops the run at the next state boundary.
REQ-007 iCONT  in  1  1 = continuous (address wraps), 0 = single pass; sampled at start.
REQ-008 iCH_MASK  in  8  enabled ADC channels; sampled at start.
REQ-009 iDIV  in  16  sample interval in iCLK cycles; 0 is treated as 1.
REQ-010 oADC_GO  out  1  conversion request to the ADC controller.
REQ-011 oADC_CH  out  3  channel for the current conversion.
REQ-012 iADC_DONE  in  1  one-cycle pulse, iADC_DATA valid.
REQ-013 iADC_DATA  in  12  conversion result.
REQ-014 oWR_EN  out  1  buffer RAM write strobe, one cycle per sample.
REQ-015 oWR_ADDR  out  DEPTH_LOG2  buffer RAM address.
REQ-016 oWR_DATA  out  8  stored sample = result[11:4].
REQ-017 oBUSY  out  1  high outside IDLE.
REQ-018 oDONE  out  1  one-cycle pulse at end of single-pass run.
REQ-019 oERR  out  1  sticky timeout flag; cleared by next accepted iSTART.

Function
REQ-020 States: IDLE, WAIT_TICK, CONVERT, WRITE, FINISH.
REQ-021 IDLE -> WAIT_TICK on iSTART when iCH_MASK != 0; iSTART with mask 0 is ignored; iSTART outside IDLE is ignored.
REQ-022 On accepted start: address := 0, tick counter := 0, channel pointer := lowest set mask bit, oERR := 0.
REQ-023 WAIT_TICK: counter counts to iDIV-1, then -> CONVERT; counter reloads to 0.
REQ-024 CONVERT: oADC_GO held high and oADC_CH stable until iADC_DONE; data captured in the cycle iADC_DONE is high; -> WRITE.
REQ-025 WRITE: oWR_EN high exactly one cycle, the cycle after iADC_DONE (latency 1), with current oWR_ADDR/oWR_DATA.
REQ-026 After WRITE: channel pointer advances to the next set mask bit, wrapping 7 -> 0 (round-robin); address increments.
REQ-027 Single pass: write to address 2^DEPTH_LOG2-1 -> FINISH; FINISH pulses oDONE one cycle -> IDLE.
REQ-028 Continuous: address wraps to 0, returns to WAIT_TICK, never pulses oDONE.
REQ-029 Timeout: TIMEOUT cycles in CONVERT without iADC_DONE -> oERR := 1, oADC_GO := 0, -> IDLE, no write, no oDONE.
REQ-030 iABORT in WAIT_TICK or CONVERT -> IDLE next cycle, oADC_GO low, no write, no oDONE; an iADC_DONE coinciding with abort is discarded.
REQ-031 iABORT during WRITE: the write completes, then -> IDLE.
REQ-032 iDIV is sampled continuously; a change takes effect at the next reload.

Reset
REQ-033 iRST_n low: state IDLE, oADC_GO/oWR_EN/oBUSY/oDONE/oERR = 0, oADC_CH = 0, oWR_ADDR = 0, oWR_DATA = 0, counters 0, immediately and asynchronously.
REQ-034 Reset mid-conversion abandons the run; no write is issued after reset release until a new iSTART.

Configuration
REQ-035 Macro ADC_SEQ_AVG_EN defined: CONVERT issues 4 back-to-back conversions on the same channel, accumulating the 14-bit sum; stored value = sum[13:6]; timeout applies per conversion.
REQ-036 ADC_SEQ_AVG_EN undefined: one conversion per sample, stored value = iADC_DATA[11:4]; no accumulator logic.

Verification
REQ-037 Mask 8'b0000_0101, iDIV=4, iCONT=0, ADC model returns 12'hAB0 after 10 cycles -> 32 writes, channels alternate 0,2,0,...; data 8'hAB; addresses 0..31; one oDONE pulse; oBUSY low after.
REQ-038 iCONT=1, mask 8'h80 -> address 31 followed by address 0, channel always 7, no oDONE.
REQ-039 ADC model never asserts iADC_DONE, TIMEOUT=1023 -> oADC_GO falls after 1023 cycles, oERR=1, no oWR_EN; next iSTART clears oERR.
REQ-040 iABORT asserted in the same cycle as iADC_DONE -> no oWR_EN, IDLE next cycle; iSTART with mask 0 -> oBUSY stays 0.
REQ-041 iRST_n pulsed low mid-CONVERT -> all outputs 0 within the reset cycle, no write after release.
REQ-042 With ADC_SEQ_AVG_EN, returns 12'h100, 12'h104, 12'h108, 12'h10C -> 4 oADC_GO handshakes, one write, data 8'h10.
